// File: rtl/cdc_pkg.sv
// ---------------------------------------------------------------------------
// cdc_pkg
// Shared definitions for the clock-domain-crossing FIFO controllers.
//   - CDC_MAX_W      : widest pointer the helper functions handle
//   - ptr_w()        : pointer width for a given RAM address width
//                      (ADDR_WIDTH + 1, the extra MSB is the wrap bit)
//   - bin2gray()     : binary -> reflected gray
//   - gray2bin()     : reflected gray -> binary
// The helpers work on zero-extended CDC_MAX_W-bit vectors. Upper zero bits
// do not change either encoding, so callers cast their PTR_W-bit values in
// and truncate the result back.
// ---------------------------------------------------------------------------
package cdc_pkg;

  localparam int CDC_MAX_W      = 32;
  localparam int ADDR_WIDTH_DEF = 3;

  function automatic int ptr_w(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic logic [CDC_MAX_W-1:0] bin2gray(input logic [CDC_MAX_W-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [CDC_MAX_W-1:0] gray2bin(input logic [CDC_MAX_W-1:0] gray);
    logic [CDC_MAX_W-1:0] bin;
    bin = '0;
    for (int i = 0; i < CDC_MAX_W; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/cdc_gray2bin.sv
// ---------------------------------------------------------------------------
// cdc_gray2bin
// Purely combinational gray -> binary decoder. Each binary bit is the XOR of
// all gray bits at and above its position (XOR-prefix from the MSB). It is
// shared with the write-side controller.
// Ports:
//   i_gray  in  W  gray-coded value
//   o_bin   out W  binary value
// ---------------------------------------------------------------------------
module cdc_gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_gray,
  output logic [W-1:0] o_bin
);

  for (genvar g = 0; g < W; g++) begin : g_bit
    assign o_bin[g] = ^(i_gray >> g);
  end

endmodule

// File: rtl/cdc_rd_ctrl_prefetch.sv
// ---------------------------------------------------------------------------
// cdc_rd_ctrl_prefetch
// Read-side controller of the AXI4 interconnect CDC FIFO. Owns the read
// pointer (binary and gray, with wrap bit), detects empty against the
// synchronised write pointer, drives a registered-read RAM and keeps a
// one-entry prefetch so data is presented first-word-fall-through with one
// pop per cycle when streaming.
//
// Optional feature macro: CDC_RD_LEVEL_EN
//   defined   : o_rdLevel / o_almostEmpty are registered level reporting
//   undefined : both tied to 0, no gray decoder is built
//
// Ports:
//   i_clk           in   1      read-domain clock
//   i_rst           in   1      synchronous active-high reset
//   i_wrPtr_gray    in   PTR_W  write pointer (gray), already synchronised
//   i_readyForOut   in   1      downstream ready
//   o_rdPtr_gray    out  PTR_W  registered read pointer (gray)
//   o_ramRdAddr     out  AW     RAM read address
//   o_ramRe         out  1      RAM read enable (data valid next edge)
//   o_infoOutValid  out  1      output data valid
//   o_fifoRe        out  1      pop handshake (valid & ready)
//   o_rdLevel       out  PTR_W  unfetched entries in RAM (optional)
//   o_almostEmpty   out  1      rdLevel <= AEMPTY_THRESH (optional)
// ---------------------------------------------------------------------------
module cdc_rd_ctrl_prefetch
  import cdc_pkg::*;
#(
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int AEMPTY_THRESH = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [ADDR_WIDTH:0]   i_wrPtr_gray,
  input  logic                  i_readyForOut,
  output logic [ADDR_WIDTH:0]   o_rdPtr_gray,
  output logic [ADDR_WIDTH-1:0] o_ramRdAddr,
  output logic                  o_ramRe,
  output logic                  o_infoOutValid,
  output logic                  o_fifoRe,
  output logic [ADDR_WIDTH:0]   o_rdLevel,
  output logic                  o_almostEmpty
);

  localparam int PTR_W = ptr_w(ADDR_WIDTH);

  logic [PTR_W-1:0] r_rdPtr_bin;
  logic [PTR_W-1:0] r_rdPtr_gray;
  logic             r_valid;

  logic             w_empty;
  logic             w_ramRe;
  logic             w_valid_next;
  logic [PTR_W-1:0] w_rdPtr_bin_next;
  logic [PTR_W-1:0] w_rdPtr_gray_next;

  // Empty detect, RAM fetch decision and next pointer / valid values.
  always_comb begin
    w_empty           = (r_rdPtr_gray == i_wrPtr_gray);
    // Fetch whenever data exists and the output slot is free or being popped.
    w_ramRe           = ~w_empty & (~r_valid | i_readyForOut);
    w_rdPtr_bin_next  = r_rdPtr_bin;
    w_valid_next      = r_valid;
    if (w_ramRe) begin
      w_rdPtr_bin_next = r_rdPtr_bin + PTR_W'(1);
    end else begin
      w_rdPtr_bin_next = r_rdPtr_bin;
    end
    // Gray register is loaded from the next binary value so the port is a
    // clean flop output for the write-domain synchroniser.
    w_rdPtr_gray_next = PTR_W'(bin2gray(CDC_MAX_W'(w_rdPtr_bin_next)));
    if (w_ramRe) begin
      w_valid_next = 1'b1;
    end else if (i_readyForOut) begin
      w_valid_next = 1'b0;
    end else begin
      w_valid_next = r_valid;
    end
  end

  // Read pointer and output-valid state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdPtr_bin  <= '0;
      r_rdPtr_gray <= '0;
      r_valid      <= 1'b0;
    end else begin
      r_rdPtr_bin  <= w_rdPtr_bin_next;
      r_rdPtr_gray <= w_rdPtr_gray_next;
      r_valid      <= w_valid_next;
    end
  end

  assign o_rdPtr_gray   = r_rdPtr_gray;
  assign o_ramRdAddr    = r_rdPtr_bin[ADDR_WIDTH-1:0];
  assign o_ramRe        = w_ramRe;
  assign o_infoOutValid = r_valid;
  assign o_fifoRe       = r_valid & i_readyForOut;

`ifdef CDC_RD_LEVEL_EN
  localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AEMPTY_THRESH);

  logic [PTR_W-1:0] w_wrPtr_bin;
  logic [PTR_W-1:0] w_level_next;
  logic [PTR_W-1:0] r_rdLevel;
  logic             r_almostEmpty;

  cdc_gray2bin #(
    .W (PTR_W)
  ) u_wr_gray2bin (
    .i_gray (i_wrPtr_gray),
    .o_bin  (w_wrPtr_bin)
  );

  // Level counts entries still in RAM after this cycle's fetch; the wrap bit
  // makes the modulo difference cover the full 0..depth range.
  assign w_level_next = w_wrPtr_bin - w_rdPtr_bin_next;

  // Level and almost-empty registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rdLevel     <= '0;
      r_almostEmpty <= 1'b1;
    end else begin
      r_rdLevel     <= w_level_next;
      r_almostEmpty <= (w_level_next <= AE_TH);
    end
  end

  assign o_rdLevel     = r_rdLevel;
  assign o_almostEmpty = r_almostEmpty;
`else
  assign o_rdLevel     = '0;
  assign o_almostEmpty = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_rd_ctrl_prefetch.sv
// ---------------------------------------------------------------------------
// tb_cdc_rd_ctrl_prefetch
// Directed bench for cdc_rd_ctrl_prefetch (ADDR_WIDTH=3, AEMPTY_THRESH=1).
// Inputs change 1 ns after the rising edge; outputs are checked 1 ns later.
// ---------------------------------------------------------------------------
module tb_cdc_rd_ctrl_prefetch;

  logic       clk;
  logic       rst;
  logic [3:0] wr_gray;
  logic       ready;
  logic [3:0] rd_gray;
  logic [2:0] ram_addr;
  logic       ram_re;
  logic       out_valid;
  logic       fifo_re;
  logic [3:0] rd_level;
  logic       almost_empty;

  int n_checks = 0;
  int n_fail   = 0;

  cdc_rd_ctrl_prefetch #(
    .ADDR_WIDTH    (3),
    .AEMPTY_THRESH (1)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_wrPtr_gray   (wr_gray),
    .i_readyForOut  (ready),
    .o_rdPtr_gray   (rd_gray),
    .o_ramRdAddr    (ram_addr),
    .o_ramRe        (ram_re),
    .o_infoOutValid (out_valid),
    .o_fifoRe       (fifo_re),
    .o_rdLevel      (rd_level),
    .o_almostEmpty  (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst     = 1'b1;
    wr_gray = 4'b0000;
    ready   = 1'b0;
    tick();
    rst     = 1'b0;
  endtask

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  int fetched;
  int pops;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1; wr_gray = 4'b0000; ready = 1'b0;
    tick(); tick(); #1;
    check_eq("rst_rdgray", 32'(rd_gray), 32'h0);
    check_eq("rst_valid", 32'(out_valid), 32'h0);
    check_eq("rst_ramre", 32'(ram_re), 32'h0);
    check_eq("rst_fifore", 32'(fifo_re), 32'h0);
    check_eq("rst_level", 32'(rd_level), 32'h0);
`ifdef CDC_RD_LEVEL_EN
    check_eq("rst_aempty", 32'(almost_empty), 32'h1);
`else
    check_eq("rst_aempty", 32'(almost_empty), 32'h0);
`endif
    rst = 1'b0;

    // ---------------- single entry ----------------
    wr_gray = 4'b0001; ready = 1'b0;
    #1;
    check_eq("single_ramre", 32'(ram_re), 32'h1);
    check_eq("single_addr", 32'(ram_addr), 32'h0);
    tick(); #1;
    check_eq("single_valid", 32'(out_valid), 32'h1);
    check_eq("single_rdgray", 32'(rd_gray), 32'h1);
    check_eq("single_ramre_off", 32'(ram_re), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      check_eq("single_hold", 32'(out_valid), 32'h1);
      check_eq("single_hold_ramre", 32'(ram_re), 32'h0);
    end
    ready = 1'b1;
    #1;
    check_eq("single_pop", 32'(fifo_re), 32'h1);
    tick(); #1;
    check_eq("single_valid_drop", 32'(out_valid), 32'h0);
    check_eq("single_fifore_drop", 32'(fifo_re), 32'h0);

    // ---------------- full burst ----------------
    apply_reset();
    wr_gray = 4'b1100; ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check_eq("burst_ramre", 32'(ram_re), 32'h1);
      check_eq("burst_addr", 32'(ram_addr), 32'(k));
      check_eq("burst_valid", 32'(out_valid), (k == 0) ? 32'h0 : 32'h1);
      tick();
    end
    #1;
    check_eq("burst_end_ramre", 32'(ram_re), 32'h0);
    check_eq("burst_last_valid", 32'(out_valid), 32'h1);
    check_eq("burst_rdgray", 32'(rd_gray), 32'hC);
    tick(); #1;
    check_eq("burst_valid_drop", 32'(out_valid), 32'h0);

    // ---------------- wrap-around streaming ----------------
    apply_reset();
    ready = 1'b1;
    for (int t = 0; t < 20; t++) begin
      wr_gray = gray4(t + 1);
      #1;
      check_eq("wrap_ramre", 32'(ram_re), 32'h1);
      check_eq("wrap_addr", 32'(ram_addr), 32'(t % 8));
      check_eq("wrap_valid", 32'(out_valid), (t == 0) ? 32'h0 : 32'h1);
      if (t == 15) check_eq("wrap_gray15", 32'(rd_gray), 32'h8);
      if (t == 16) check_eq("wrap_gray16", 32'(rd_gray), 32'h0);
      tick();
    end
    #1;
    check_eq("wrap_end_ramre", 32'(ram_re), 32'h0);
    check_eq("wrap_end_valid", 32'(out_valid), 32'h1);
    check_eq("wrap_end_rdgray", 32'(rd_gray), 32'h6);

    // ---------------- backpressure ----------------
    apply_reset();
    wr_gray = 4'b1100;
    fetched = 0;
    pops    = 0;
    for (int c = 0; c < 30; c++) begin
      ready = (c % 2 == 0);
      #1;
      check_eq("bp_no_fetch_stalled", 32'(ram_re & out_valid & ~ready), 32'h0);
      if (ram_re) begin
        check_eq("bp_addr_order", 32'(ram_addr), 32'(fetched % 8));
        fetched++;
      end
      if (fifo_re) pops++;
      tick();
    end
    check_eq("bp_fetch_count", 32'(fetched), 32'd8);
    check_eq("bp_pop_count", 32'(pops), 32'd8);

    // ---------------- reset mid-stream / level ----------------
    apply_reset();
    ready   = 1'b0;
    wr_gray = 4'b0001;
    tick();
    wr_gray = gray4(6);
    tick(); #1;
    check_eq("mid_valid", 32'(out_valid), 32'h1);
`ifdef CDC_RD_LEVEL_EN
    check_eq("mid_level", 32'(rd_level), 32'd5);
    check_eq("mid_aempty", 32'(almost_empty), 32'h0);
`else
    check_eq("mid_level", 32'(rd_level), 32'd0);
    check_eq("mid_aempty", 32'(almost_empty), 32'h0);
`endif
    rst = 1'b1;
    tick(); #1;
    check_eq("mid_rst_valid", 32'(out_valid), 32'h0);
    check_eq("mid_rst_rdgray", 32'(rd_gray), 32'h0);
    check_eq("mid_rst_level", 32'(rd_level), 32'h0);
    check_eq("mid_rst_addr", 32'(ram_addr), 32'h0);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
